// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters. A
// round-robin arbiter picks one requester per packet. The grant stays with
// that requester until its last byte has been accepted by the transmit
// buffer. Bytes go to the transmitter through the Data_in / TBR_en /
// TBR_Valid handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset (0 = reset)
//   req_valid    per requester: a byte is presented
//   req_data     per requester byte, requester i in bits [8i+7:8i]
//   req_last     per requester: presented byte ends the packet
//   req_ack      per requester one-cycle pulse: byte was taken
//   tbr_valid    transmitter buffer full (TBR_Valid)
//   tbr_data     byte to transmitter Data_in
//   tbr_en       one-cycle load strobe to transmitter TBR_en
//   grant        one-hot current owner, zero when idle
//   busy         an owner exists
//   timeout_err  one-cycle pulse when an idle owner loses its grant
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 tbr_valid,
    output logic [7:0]           tbr_data,
    output logic                 tbr_en,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ARB,
        CONFIRM,
        HOLD
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   owner, owner_next;
    logic [IDX_W-1:0]   last_owner, last_owner_next;
    logic               last_flag, last_flag_next;
    logic [TO_W-1:0]    counter, counter_next;

    logic [NUM_REQ-1:0] req_ack_next;
    logic [7:0]         tbr_data_next;
    logic               tbr_en_next;
    logic [NUM_REQ-1:0] grant_next;
    logic               busy_next;
    logic               timeout_err_next;

    logic               issue;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   rr_winner;

    // Round-robin search starting just after the previous owner, so the
    // requester that finished most recently is considered last.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [IDX_W-1:0]   last
    );
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        cand  = last;
        pick  = last;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == IDX_W'(NUM_REQ - 1))
                cand = '0;
            else
                cand = cand + IDX_W'(1);
            if (!found && valid[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign rr_winner = rr_pick(req_valid, last_owner);

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so outputs never depend combinationally on inputs.
    always_comb begin
        state_next       = state;
        owner_next       = owner;
        last_owner_next  = last_owner;
        last_flag_next   = last_flag;
        counter_next     = counter;
        req_ack_next     = '0;
        tbr_data_next    = tbr_data;
        tbr_en_next      = 1'b0;
        grant_next       = grant;
        timeout_err_next = 1'b0;
        issue            = 1'b0;
        issue_idx        = owner;

        case (state)
            ARB: begin
                if (!tbr_valid && (|req_valid)) begin
                    issue     = 1'b1;
                    issue_idx = rr_winner;
                end
            end
            CONFIRM: begin
                // No further load until the transmitter has shown it took
                // the byte; TBR_Valid can lag the load strobe by a cycle.
                if (tbr_valid) begin
                    if (last_flag) begin
                        grant_next      = '0;
                        last_owner_next = owner;
                        state_next      = ARB;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the owner is served. A waiting owner under
                // backpressure keeps the counter frozen; only an owner with
                // nothing to send runs the timeout.
                if (req_valid[owner]) begin
                    if (!tbr_valid) begin
                        issue     = 1'b1;
                        issue_idx = owner;
                    end
                end else if (counter == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_next = 1'b1;
                    grant_next       = '0;
                    last_owner_next  = owner;
                    state_next       = ARB;
                end else begin
                    counter_next = counter + TO_W'(1);
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase

        if (issue) begin
            tbr_data_next           = req_data[{issue_idx, 3'b000} +: 8];
            tbr_en_next             = 1'b1;
            req_ack_next[issue_idx] = 1'b1;
            grant_next              = '0;
            grant_next[issue_idx]   = 1'b1;
            owner_next              = issue_idx;
            last_flag_next          = req_last[issue_idx];
            counter_next            = '0;
            state_next              = CONFIRM;
        end

        busy_next = |grant_next;
    end

    // State and output registers. Reset drops any packet in flight without
    // raising timeout_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB;
            owner       <= '0;
            last_owner  <= IDX_W'(NUM_REQ - 1);
            last_flag   <= 1'b0;
            counter     <= '0;
            req_ack     <= '0;
            tbr_data    <= '0;
            tbr_en      <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            last_owner  <= last_owner_next;
            last_flag   <= last_flag_next;
            counter     <= counter_next;
            req_ack     <= req_ack_next;
            tbr_data    <= tbr_data_next;
            tbr_en      <= tbr_en_next;
            grant       <= grant_next;
            busy        <= busy_next;
            timeout_err <= timeout_err_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and TIMEOUT=8. A small
// transmitter model raises tbr_valid the cycle after a load strobe and keeps
// it high for TX_HOLD cycles; it can be switched off to drive tbr_valid by
// hand for the backpressure case.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 16;
    localparam int TX_HOLD = 2;

    logic                 clk;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tbr_valid;
    logic [7:0]           tbr_data;
    logic                 tbr_en;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 timeout_err;

    int n_checks;
    int n_fail;
    int cyc;
    int tx_left;
    bit model_auto;
    int cap_n;
    logic [7:0]         cap_data  [16];
    logic [NUM_REQ-1:0] cap_grant [16];
    int te_count;
    int te_cycle;
    int byte_idx;

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .tbr_valid   (tbr_valid),
        .tbr_data    (tbr_data),
        .tbr_en      (tbr_en),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one requester's valid/data/last.
    task automatic applyStimulus(input int idx, input logic v, input logic [7:0] d,
                                 input logic l);
        req_valid[idx]       = v;
        req_data[8*idx +: 8] = d;
        req_last[idx]        = l;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; the transmitter model
    // reacts to the strobe that was present during the cycle just ended.
    task automatic tick();
        logic prev_en;
        prev_en = tbr_en;
        @(posedge clk);
        #1;
        cyc++;
        if (model_auto) begin
            if (prev_en) begin
                tbr_valid = 1'b1;
                tx_left   = TX_HOLD;
            end else if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) tbr_valid = 1'b0;
            end
        end
        if (tbr_en) begin
            if (cap_n < 16) begin
                cap_data[cap_n]  = tbr_data;
                cap_grant[cap_n] = grant;
            end
            cap_n++;
        end
        if (timeout_err) begin
            te_count++;
            te_cycle = cyc;
        end
    endtask

    task automatic doReset();
        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tbr_valid  = 1'b0;
        tx_left    = 0;
        model_auto = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        cyc      = 0;
        cap_n    = 0;
        te_count = 0;
        te_cycle = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        cap_n      = 0;
        te_count   = 0;
        te_cycle   = 0;
        tx_left    = 0;
        model_auto = 1'b1;
        reset      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tbr_valid  = 1'b0;

        // Reset values
        #3;
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_tbr_en", tbr_en, 0);
        checkOutput("rst_req_ack", req_ack, 0);
        checkOutput("rst_tbr_data", tbr_data, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);

        // Single byte packet
        $display("[TB] single byte");
        doReset();
        applyStimulus(0, 1'b1, 8'h41, 1'b1);
        tick();
        checkOutput("single_tbr_en", tbr_en, 1);
        checkOutput("single_req_ack", req_ack, 4'b0001);
        checkOutput("single_tbr_data", tbr_data, 8'h41);
        checkOutput("single_grant", grant, 4'b0001);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("single_en_pulse", tbr_en, 0);
        checkOutput("single_ack_pulse", req_ack, 0);
        checkOutput("single_busy_c2", busy, 1);
        tick();
        checkOutput("single_grant_c3", grant, 0);
        checkOutput("single_busy_c3", busy, 0);
        repeat (4) tick();
        checkOutput("single_en_count", cap_n, 1);

        // Round-robin between requesters 0 and 2
        $display("[TB] round robin");
        doReset();
        applyStimulus(0, 1'b1, 8'h10, 1'b1);
        applyStimulus(2, 1'b1, 8'h20, 1'b1);
        repeat (24) tick();
        checkOutput("rr_count_min", (cap_n >= 4) ? 1 : 0, 1);
        checkOutput("rr_byte0", cap_data[0], 8'h10);
        checkOutput("rr_byte1", cap_data[1], 8'h20);
        checkOutput("rr_byte2", cap_data[2], 8'h10);
        checkOutput("rr_byte3", cap_data[3], 8'h20);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);
        repeat (6) tick();

        // Packet lock: requester 1 sends three bytes while requester 0 waits
        $display("[TB] packet lock");
        doReset();
        byte_idx = 0;
        applyStimulus(1, 1'b1, 8'hA1, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 8'h55, 1'b1);
        for (int t = 0; t < 40; t++) begin
            if (req_ack[1]) begin
                byte_idx++;
                if (byte_idx == 1)      applyStimulus(1, 1'b1, 8'hA2, 1'b0);
                else if (byte_idx == 2) applyStimulus(1, 1'b1, 8'hA3, 1'b1);
                else                    applyStimulus(1, 1'b0, 8'h00, 1'b0);
            end
            if (req_ack[0]) applyStimulus(0, 1'b0, 8'h00, 1'b0);
            tick();
        end
        checkOutput("lock_count", cap_n, 4);
        checkOutput("lock_b0", cap_data[0], 8'hA1);
        checkOutput("lock_b1", cap_data[1], 8'hA2);
        checkOutput("lock_b2", cap_data[2], 8'hA3);
        checkOutput("lock_b3", cap_data[3], 8'h55);
        checkOutput("lock_g1", cap_grant[1], 4'b0010);
        checkOutput("lock_g2", cap_grant[2], 4'b0010);
        checkOutput("lock_g3", cap_grant[3], 4'b0001);

        // Backpressure: transmitter busy for 50 cycles while owner waits
        $display("[TB] backpressure");
        doReset();
        model_auto = 1'b0;
        applyStimulus(0, 1'b1, 8'h61, 1'b0);
        tick();
        checkOutput("bp_first_en", tbr_en, 1);
        applyStimulus(0, 1'b1, 8'h62, 1'b1);
        tbr_valid = 1'b1;
        cap_n    = 0;
        te_count = 0;
        repeat (50) tick();
        checkOutput("bp_no_en", cap_n, 0);
        checkOutput("bp_no_timeout", te_count, 0);
        checkOutput("bp_still_owner", grant, 4'b0001);
        tbr_valid = 1'b0;
        tick();
        checkOutput("bp_release_en", tbr_en, 1);
        checkOutput("bp_release_data", tbr_data, 8'h62);
        tbr_valid = 1'b1;
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        tick();
        checkOutput("bp_done_grant", grant, 0);
        tbr_valid  = 1'b0;
        model_auto = 1'b1;
        repeat (3) tick();

        // Timeout: owner 1 stops after a non-last byte, requester 3 waits
        $display("[TB] timeout");
        doReset();
        applyStimulus(1, 1'b1, 8'h71, 1'b0);
        applyStimulus(3, 1'b1, 8'h33, 1'b1);
        tick();
        checkOutput("to_first_ack", req_ack, 4'b0010);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        cap_n    = 0;
        te_count = 0;
        repeat (11) tick();
        checkOutput("to_pulse_count", te_count, 1);
        checkOutput("to_pulse_cycle", te_cycle, 11);
        checkOutput("to_next_en_count", cap_n, 1);
        checkOutput("to_next_data", tbr_data, 8'h33);
        checkOutput("to_next_grant", grant, 4'b1000);
        checkOutput("to_next_ack", req_ack, 4'b1000);
        applyStimulus(3, 1'b0, 8'h00, 1'b0);
        repeat (6) tick();

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        doReset();
        applyStimulus(2, 1'b1, 8'h81, 1'b0);
        tick();
        checkOutput("mid_en", tbr_en, 1);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        checkOutput("mid_hold_grant", grant, 4'b0100);
        #2;
        reset     = 1'b0;
        tbr_valid = 1'b0;
        tx_left   = 0;
        #1;
        checkOutput("mid_rst_grant", grant, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_tbr_data", tbr_data, 0);
        checkOutput("mid_rst_tbr_en", tbr_en, 0);
        checkOutput("mid_rst_timeout", timeout_err, 0);
        tick();
        tick();
        reset    = 1'b1;
        cap_n    = 0;
        te_count = 0;
        applyStimulus(0, 1'b1, 8'h90, 1'b1);
        applyStimulus(2, 1'b1, 8'hA0, 1'b1);
        repeat (20) tick();
        checkOutput("mid_first_data", cap_data[0], 8'h90);
        checkOutput("mid_first_grant", cap_grant[0], 4'b0001);
        checkOutput("mid_no_timeout", te_count, 0);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(2, 1'b0, 8'h00, 1'b0);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the Forth console, the debug monitor and the boot loader. Selects one requester per packet by round-robin and holds the grant until that requester's last byte. Feeds bytes into the transmit buffer register through its Data_in/TBR_en/TBR_Valid handshake. Sits between the requesters and the UART transmit top level, sharing its clk and reset.

Parameters:
NUM_REQ, 4, number of requesters, 2..8.
TIMEOUT, 1024, cycles a locked owner may leave req_valid low before its grant is revoked, 2..65535.
TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  system clock, all state updates on rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
req_last  in  NUM_REQ  byte of requester i is the last of its packet.
req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i was taken.
tbr_valid  in  1  transmit buffer full, the TBR_Valid output of the transmitter.
tbr_data  out  8  byte to the transmitter Data_in.
tbr_en  out  1  one-cycle load strobe to the transmitter TBR_en.
grant  out  NUM_REQ  one-hot current owner; all zero when no owner.
busy  out  1  high when an owner exists (state CONFIRM or HOLD).
timeout_err  out  1  one-cycle pulse when an owner's grant is revoked by timeout.

Behaviour:
- All outputs are registered.
- Reset values: req_ack=0, tbr_data=0, tbr_en=0, grant=0, busy=0, timeout_err=0, state=ARB, last_owner=NUM_REQ-1, timeout counter=0.
- Reset mid-packet drops the packet silently, with no error pulse.
- Requester rule: hold req_valid, req_data and req_last stable until req_ack. After req_ack, the next byte may be presented on the following cycle.
- ARB:
  - Issue only when tbr_valid=0 and any req_valid is high.
  - Winner = first i with req_valid[i] high, searching last_owner+1, last_owner+2, ... modulo NUM_REQ.
  - At that edge: tbr_data<=req_data[w], tbr_en<=1, req_ack[w]<=1, grant<=onehot(w), last_flag<=req_last[w], counter<=0, go to CONFIRM.
  - Latency: requester valid in cycle 0 gives tbr_en and req_ack high in cycle 1.
- CONFIRM:
  - tbr_en and req_ack are zero from the second cycle of CONFIRM onward.
  - Wait for tbr_valid=1, which normally arrives in cycle 2.
  - Then: if last_flag=1, grant<=0, last_owner<=owner, go to ARB. Otherwise go to HOLD.
  - No new byte is issued before tbr_valid has been seen high. This prevents a double load while TBR_Valid lags tbr_en.
- HOLD (owner locked; other requesters are ignored even if valid):
  - tbr_valid=0 and req_valid[owner]=1: issue exactly as in ARB for the owner only, counter<=0, go to CONFIRM.
  - req_valid[owner]=0: counter increments each cycle. When counter reaches TIMEOUT-1: timeout_err<=1 for one cycle, grant<=0, last_owner<=owner, go to ARB.
  - req_valid[owner]=1 with tbr_valid=1 (transmitter busy): counter holds. Backpressure never causes a timeout.
- Simultaneous requests: round-robin order only. A requester that just finished has lowest priority in the next ARB.
- busy = (grant != 0).

Test Plan:
- Single byte: req_valid[0]=1, data=0x41, last=1, tbr_valid=0 -> tbr_en and req_ack[0] high in cycle 1 with tbr_data=0x41; model tbr_valid high in cycle 2 -> grant=0 by cycle 3; exactly one tbr_en.
- Round-robin: req 0 and 2 both valid with single-byte packets 0x10 and 0x20, repeated -> tbr_data sequence 0x10, 0x20, 0x10, 0x20; after reset, req 0 wins first.
- Packet lock: req 1 sends 3-byte packet 0xA1, 0xA2, 0xA3 (last on 0xA3) while req 0 is continuously valid -> all three A-bytes are sent before any req 0 byte; grant stays 0010 throughout.
- Backpressure: tbr_valid held at 1 for 50 cycles during HOLD with owner valid -> no tbr_en, no timeout_err; byte issued the cycle after tbr_valid falls.
- Timeout: TIMEOUT=8; owner sends a non-last byte, then drops req_valid -> timeout_err pulses once exactly 8 cycles after entering HOLD; a waiting req 3 is granted next.
- Reset mid-packet: assert reset during HOLD -> all outputs 0 immediately (asynchronously); after release, req 0 has first priority and no timeout_err is produced.
